// File: rtl/cam_capture_pkg.sv
// Shared types for the camera capture block: FSM state encoding and the
// byte-within-pixel index used by the packer.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        LINE,
        BLANK
    } state_t;

    // Two bits cover every supported pixel width (1..4 bytes).
    typedef logic [1:0] byte_idx_t;

endpackage

// File: rtl/cam_pixel_pack.sv
// Packs consecutive camera bytes into one pixel word (first byte in the MSBs)
// and raises a one-cycle write strobe the cycle after the last byte arrives.
module cam_pixel_pack
    import cam_capture_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2
) (
    input  logic                            PCLK,
    input  logic                            RST_N,
    input  logic                            byte_valid,
    input  logic [DATA_W-1:0]               byte_data,
    output logic                            pix_wr,
    output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data
);

    localparam int        PIX_W    = DATA_W * BYTES_PER_PIX;
    localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_PIX - 1);

    byte_idx_t idx;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            idx      <= '0;
            pix_wr   <= 1'b0;
            pix_data <= '0;
        end else begin
            pix_wr <= 1'b0;
            if (byte_valid) begin
                // The shift register doubles as the output word: it is complete
                // exactly during the strobe cycle.
                pix_data <= PIX_W'({pix_data, byte_data});
                if (idx == LAST_IDX) begin
                    idx    <= '0;
                    pix_wr <= 1'b1;
                end else begin
                    idx <= idx + 2'd1;
                end
            end else begin
                // Any partial pixel left when HREF drops is forgotten here.
                idx <= '0;
            end
        end
    end

endmodule

// File: rtl/cam_capture.sv
// Camera (VSYNC/HREF) capture into a ping-pong line buffer. Defining
// CAM_CAPTURE_CROP_EN adds a rectangular crop window (CROP_X0/X1, CROP_Y0/Y1).
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int ADDR_W        = 10,
    parameter int LINE_W        = 9
) (
    input  logic                            PCLK,
    input  logic                            RST_N,
    input  logic                            CAP_EN,
    input  logic                            CAM_VSYNC,
    input  logic                            CAM_HREF,
    input  logic [DATA_W-1:0]               CAM_DATA,
`ifdef CAM_CAPTURE_CROP_EN
    input  logic [ADDR_W-1:0]               CROP_X0,
    input  logic [ADDR_W-1:0]               CROP_X1,
    input  logic [LINE_W-1:0]               CROP_Y0,
    input  logic [LINE_W-1:0]               CROP_Y1,
`endif
    output logic                            LB_WR_EN,
    output logic [ADDR_W-1:0]               LB_WR_ADDR,
    output logic [DATA_W*BYTES_PER_PIX-1:0] LB_WR_DATA,
    output logic                            LB_BANK,
    output logic                            LINE_DONE,
    output logic                            FRAME_DONE,
    output logic [LINE_W-1:0]               LINE_COUNT,
    output logic                            PIX_OVF
);

    state_t state, state_nxt;
    logic vsync_q, href_q;
    logic vsync_rise, vsync_fall, href_rise, href_fall;
    logic frame_start, frame_end, line_end, byte_valid, clear_ovf;
    logic line_clear, pix_wr, in_x, in_y, wr_take, addr_full;
    logic [ADDR_W-1:0] addr;

    assign vsync_rise = CAM_VSYNC & ~vsync_q;
    assign vsync_fall = ~CAM_VSYNC & vsync_q;
    assign href_rise  = CAM_HREF & ~href_q;
    assign href_fall  = ~CAM_HREF & href_q;

    // NOTE: every combinational output is defaulted first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        line_end    = 1'b0;
        byte_valid  = 1'b0;
        clear_ovf   = 1'b0;
        case (state)
            IDLE: if (CAP_EN && CAM_VSYNC) begin
                state_nxt = WAIT_FRAME;
                clear_ovf = 1'b1;
            end
            WAIT_FRAME: if (vsync_fall) begin
                state_nxt   = BLANK;
                frame_start = 1'b1;
            end
            BLANK: if (vsync_rise) begin
                state_nxt = IDLE;
                frame_end = 1'b1;
            end else if (href_rise) begin
                state_nxt  = LINE;
                byte_valid = 1'b1;
            end
            LINE: if (vsync_rise) begin
                state_nxt = IDLE;
                frame_end = 1'b1;
            end else if (href_fall) begin
                state_nxt = BLANK;
                line_end  = 1'b1;
            end else begin
                byte_valid = CAM_HREF;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign line_clear = line_end | frame_end | (state == IDLE) | (state == WAIT_FRAME);

    cam_pixel_pack #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX)
    ) u_pack (
        .PCLK       (PCLK),
        .RST_N      (RST_N),
        .byte_valid (byte_valid),
        .byte_data  (CAM_DATA),
        .pix_wr     (pix_wr),
        .pix_data   (LB_WR_DATA)
    );

`ifdef CAM_CAPTURE_CROP_EN
    // One spare bit so long lines saturate past the window instead of wrapping into it.
    logic [ADDR_W:0] pix_x;
    assign in_x = (pix_x >= {1'b0, CROP_X0}) && (pix_x <= {1'b0, CROP_X1});
    assign in_y = (LINE_COUNT >= CROP_Y0) && (LINE_COUNT <= CROP_Y1);

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N)                      pix_x <= '0;
        else if (line_clear)             pix_x <= '0;
        else if (pix_wr && pix_x != '1)  pix_x <= pix_x + 1'b1;
    end
`else
    assign in_x = 1'b1;
    assign in_y = 1'b1;
`endif

    assign wr_take    = pix_wr & in_x & in_y & ~addr_full;
    assign LB_WR_EN   = wr_take;
    assign LB_WR_ADDR = addr;

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            addr       <= '0;
            addr_full  <= 1'b0;
            LINE_DONE  <= 1'b0;
            FRAME_DONE <= 1'b0;
            LB_BANK    <= 1'b0;
            LINE_COUNT <= '0;
            PIX_OVF    <= 1'b0;
        end else begin
            state      <= state_nxt;
            vsync_q    <= CAM_VSYNC;
            href_q     <= CAM_HREF;
            LINE_DONE  <= line_end & in_y;
            FRAME_DONE <= frame_end;
            if (line_end && in_y)
                LB_BANK <= ~LB_BANK;
            if (frame_start)
                LINE_COUNT <= '0;
            else if (line_end && LINE_COUNT != '1)
                LINE_COUNT <= LINE_COUNT + 1'b1;
            if (clear_ovf)
                PIX_OVF <= 1'b0;
            else if (pix_wr && in_x && in_y && addr_full)
                PIX_OVF <= 1'b1;
            // The last address is written once; later pixels on the line are dropped.
            if (line_clear) begin
                addr      <= '0;
                addr_full <= 1'b0;
            end else if (wr_take) begin
                if (addr == '1) addr_full <= 1'b1;
                else            addr      <= addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: a default instance plus an ADDR_W=3 instance
// sharing stimulus so line overflow can be exercised with short lines.
module tb_cam_capture;

    logic        PCLK, RST_N, CAP_EN, CAM_VSYNC, CAM_HREF;
    logic [7:0]  CAM_DATA;

    logic        LB_WR_EN, LB_BANK, LINE_DONE, FRAME_DONE, PIX_OVF;
    logic [9:0]  LB_WR_ADDR;
    logic [15:0] LB_WR_DATA;
    logic [8:0]  LINE_COUNT;

    logic        s_wr_en, s_bank, s_line_done, s_frame_done, s_pix_ovf;
    logic [2:0]  s_addr;
    logic [15:0] s_data;
    logic [8:0]  s_line_count;

`ifdef CAM_CAPTURE_CROP_EN
    logic [9:0]  crop_x0, crop_x1;
    logic [8:0]  crop_y0, crop_y1;
`endif

    cam_capture #(.DATA_W(8), .BYTES_PER_PIX(2), .ADDR_W(10), .LINE_W(9)) dut (
        .PCLK(PCLK), .RST_N(RST_N), .CAP_EN(CAP_EN), .CAM_VSYNC(CAM_VSYNC),
        .CAM_HREF(CAM_HREF), .CAM_DATA(CAM_DATA),
`ifdef CAM_CAPTURE_CROP_EN
        .CROP_X0(crop_x0), .CROP_X1(crop_x1), .CROP_Y0(crop_y0), .CROP_Y1(crop_y1),
`endif
        .LB_WR_EN(LB_WR_EN), .LB_WR_ADDR(LB_WR_ADDR), .LB_WR_DATA(LB_WR_DATA),
        .LB_BANK(LB_BANK), .LINE_DONE(LINE_DONE), .FRAME_DONE(FRAME_DONE),
        .LINE_COUNT(LINE_COUNT), .PIX_OVF(PIX_OVF)
    );

    cam_capture #(.DATA_W(8), .BYTES_PER_PIX(2), .ADDR_W(3), .LINE_W(9)) dut_s (
        .PCLK(PCLK), .RST_N(RST_N), .CAP_EN(CAP_EN), .CAM_VSYNC(CAM_VSYNC),
        .CAM_HREF(CAM_HREF), .CAM_DATA(CAM_DATA),
`ifdef CAM_CAPTURE_CROP_EN
        .CROP_X0(3'd0), .CROP_X1(3'd7), .CROP_Y0(9'd0), .CROP_Y1(9'h1FF),
`endif
        .LB_WR_EN(s_wr_en), .LB_WR_ADDR(s_addr), .LB_WR_DATA(s_data),
        .LB_BANK(s_bank), .LINE_DONE(s_line_done), .FRAME_DONE(s_frame_done),
        .LINE_COUNT(s_line_count), .PIX_OVF(s_pix_ovf)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
        logic [8:0]  line;
        logic        bank;
    } wr_rec_t;

    wr_rec_t    wq[$];
    int         ld_cnt = 0, fd_cnt = 0, s_cnt = 0;
    logic [2:0] s_last_addr = '0;
    int         errors = 0, checks = 0;

    // Write log, sampled mid-cycle on the falling edge.
    always @(negedge PCLK) begin
        if (LB_WR_EN) wq.push_back('{addr: LB_WR_ADDR, data: LB_WR_DATA, line: LINE_COUNT, bank: LB_BANK});
        if (LINE_DONE) ld_cnt++;
        if (FRAME_DONE) fd_cnt++;
        if (s_wr_en) begin
            s_cnt++;
            s_last_addr = s_addr;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic wr_rec_t rec(input int i);
        if (i < wq.size()) return wq[i];
        return '1;
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic send_line(input int nbytes, input int first, input int step);
        for (int k = 0; k < nbytes; k++) begin
            CAM_HREF = 1'b1;
            CAM_DATA = 8'(first + step * k);
            tick();
        end
        CAM_HREF = 1'b0;
        CAM_DATA = 8'h00;
        repeat (4) tick();
    endtask

    task automatic frame_open();
        CAM_VSYNC = 1'b1;
        repeat (3) tick();
        CAM_VSYNC = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_close();
        CAM_VSYNC = 1'b1;
        repeat (4) tick();
    endtask

    int wb, lb, fb, sb;

    initial begin
        RST_N = 1'b0; CAP_EN = 1'b0; CAM_VSYNC = 1'b0; CAM_HREF = 1'b0; CAM_DATA = 8'h00;
`ifdef CAM_CAPTURE_CROP_EN
        crop_x0 = 10'd0; crop_x1 = 10'h3FF; crop_y0 = 9'd0; crop_y1 = 9'h1FF;
`endif
        repeat (3) tick();
        check("reset_outputs", {LB_WR_EN, LB_WR_ADDR, LB_WR_DATA, LB_BANK, LINE_DONE,
                                FRAME_DONE, LINE_COUNT, PIX_OVF}, 64'd0);
        RST_N = 1'b1;
        repeat (2) tick();

        // Capture disabled: a whole frame produces nothing.
        wb = wq.size(); lb = ld_cnt; fb = fd_cnt;
        frame_open(); send_line(8, 'h11, 'h11); frame_close();
        check("disabled_writes", wq.size() - wb, 0);
        check("disabled_frame_done", fd_cnt - fb, 0);

        // Three-line frame: packing, addresses, line count, bank ping-pong.
        CAP_EN = 1'b1;
        wb = wq.size(); lb = ld_cnt; fb = fd_cnt;
        frame_open();
        send_line(8, 'h11, 'h11);
        check("l0_writes", wq.size() - wb, 4);
        check("l0_w0", {rec(wb).addr, rec(wb).data}, {10'd0, 16'h1122});
        check("l0_w1", {rec(wb+1).addr, rec(wb+1).data}, {10'd1, 16'h3344});
        check("l0_w2", {rec(wb+2).addr, rec(wb+2).data}, {10'd2, 16'h5566});
        check("l0_w3", {rec(wb+3).addr, rec(wb+3).data}, {10'd3, 16'h7788});
        check("l0_line_done", ld_cnt - lb, 1);
        send_line(4, 'hA1, 1);
        send_line(4, 'hB1, 1);
        check("l1_w0", {rec(wb+4).addr, rec(wb+4).data, rec(wb+4).line, rec(wb+4).bank},
                       {10'd0, 16'hA1A2, 9'd1, 1'b1});
        check("l2_w1", {rec(wb+7).addr, rec(wb+7).data, rec(wb+7).line, rec(wb+7).bank},
                       {10'd1, 16'hB3B4, 9'd2, 1'b0});
        check("l0_line_bank", {rec(wb+3).line, rec(wb+3).bank}, {9'd0, 1'b0});
        check("frame_line_count", LINE_COUNT, 9'd3);
        frame_close();
        check("frame_line_done", ld_cnt - lb, 3);
        check("frame_done_once", fd_cnt - fb, 1);

        // Odd byte count: trailing byte dropped, next line starts clean.
        wb = wq.size(); lb = ld_cnt;
        frame_open();
        send_line(5, 1, 1);
        send_line(4, 6, 1);
        check("odd_writes", wq.size() - wb, 4);
        check("odd_w1", {rec(wb+1).addr, rec(wb+1).data}, {10'd1, 16'h0304});
        check("odd_next_w0", {rec(wb+2).addr, rec(wb+2).data}, {10'd0, 16'h0607});
        frame_close();

        // Ten-pixel line: the ADDR_W=3 instance saturates at address 7.
        wb = wq.size(); sb = s_cnt;
        frame_open();
        send_line(20, 1, 1);
        check("ovf_big_writes", wq.size() - wb, 10);
        check("ovf_big_last", {rec(wb+9).addr, rec(wb+9).data}, {10'd9, 16'h1314});
        check("ovf_big_flag", PIX_OVF, 1'b0);
        check("ovf_small_writes", s_cnt - sb, 8);
        check("ovf_small_last_addr", s_last_addr, 3'd7);
        check("ovf_small_flag", s_pix_ovf, 1'b1);
        sb = s_cnt;
        send_line(4, 'h21, 1);
        check("ovf_next_line_writes", s_cnt - sb, 2);
        check("ovf_sticky", s_pix_ovf, 1'b1);
        frame_close();
        check("ovf_cleared_new_frame", s_pix_ovf, 1'b0);

        // VSYNC during a line aborts it; CAP_EN drop waits for frame end.
        wb = wq.size(); lb = ld_cnt; fb = fd_cnt;
        frame_open();
        CAP_EN = 1'b0;
        send_line(4, 'h31, 1);
        CAM_HREF = 1'b1;
        for (int k = 0; k < 3; k++) begin
            CAM_DATA = 8'(8'hC1 + k);
            tick();
        end
        CAM_VSYNC = 1'b1; CAM_DATA = 8'hC4;
        tick();
        CAM_HREF = 1'b0;
        repeat (3) tick();
        check("abort_writes", wq.size() - wb, 3);
        check("abort_line_done", ld_cnt - lb, 1);
        check("abort_frame_done", fd_cnt - fb, 1);
        check("abort_line_count", LINE_COUNT, 9'd1);
        wb = wq.size(); fb = fd_cnt;
        frame_open(); send_line(4, 'h41, 1); frame_close();
        check("capen_off_writes", wq.size() - wb, 0);
        check("capen_off_frame_done", fd_cnt - fb, 0);
        CAP_EN = 1'b1;

        // Asynchronous reset in the middle of a line.
        frame_open();
        send_line(4, 'h51, 1);
        CAM_HREF = 1'b1; CAM_DATA = 8'hD1;
        tick();
        CAM_DATA = 8'hD2;
        tick();
        check("pre_reset_state", {LB_WR_EN, LB_WR_DATA, LINE_COUNT, LB_BANK},
                                 {1'b1, 16'hD1D2, 9'd1, 1'b1});
        RST_N = 1'b0;
        #1;
        check("midline_reset_outputs", {LB_WR_EN, LB_WR_ADDR, LB_WR_DATA, LB_BANK, LINE_DONE,
                                        FRAME_DONE, LINE_COUNT, PIX_OVF}, 64'd0);
        check("midline_reset_small", {s_wr_en, s_addr, s_data, s_bank, s_line_done,
                                      s_frame_done, s_line_count, s_pix_ovf}, 64'd0);
        repeat (2) tick();
        RST_N = 1'b1;
        wb = wq.size();
        send_line(4, 'hD3, 1);
        check("post_reset_no_capture", wq.size() - wb, 0);
        frame_open();
        send_line(4, 'hE1, 1);
        check("resume_writes", wq.size() - wb, 2);
        check("resume_w0", {rec(wb).addr, rec(wb).data, rec(wb).line, rec(wb).bank},
                           {10'd0, 16'hE1E2, 9'd0, 1'b0});
        frame_close();

`ifdef CAM_CAPTURE_CROP_EN
        crop_x0 = 10'd2; crop_x1 = 10'd3; crop_y0 = 9'd1; crop_y1 = 9'd1;
        wb = wq.size(); lb = ld_cnt;
        frame_open();
        send_line(8, 'h10, 1);
        send_line(8, 'h20, 1);
        send_line(8, 'h30, 1);
        frame_close();
        check("crop_writes", wq.size() - wb, 2);
        check("crop_w0", {rec(wb).addr, rec(wb).data}, {10'd0, 16'h2425});
        check("crop_w1", {rec(wb+1).addr, rec(wb+1).data}, {10'd1, 16'h2627});
        check("crop_line_done", ld_cnt - lb, 1);
        crop_x0 = 10'd0; crop_x1 = 10'h3FF; crop_y0 = 9'd0; crop_y1 = 9'h1FF;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter DATA_W, default 8, camera byte width.
REQ-002 Parameter BYTES_PER_PIX, default 2, range 1..4, camera bytes packed per pixel word.
REQ-003 Parameter ADDR_W, default 10, line-buffer pixel address width.
REQ-004 Parameter LINE_W, default 9, line counter width.
REQ-005 Port PCLK  in  1  camera pixel clock; all logic in this domain.
REQ-006 Port RST_N  in  1  asynchronous, active-low reset.
REQ-007 Port CAP_EN  in  1  capture enable; sampled only at frame start.
REQ-008 Port CAM_VSYNC  in  1  frame sync; high = vertical blanking.
REQ-009 Port CAM_HREF  in  1  line valid; high = active pixel bytes.
REQ-010 Port CAM_DATA  in  DATA_W  camera byte.
REQ-011 Port LB_WR_EN  out  1  line-buffer write strobe, one PCLK.
REQ-012 Port LB_WR_ADDR  out  ADDR_W  pixel index within the line.
REQ-013 Port LB_WR_DATA  out  DATA_W*BYTES_PER_PIX  packed pixel; first byte in the MSBs.
REQ-014 Port LB_BANK  out  1  ping-pong bank being written.
REQ-015 Port LINE_DONE  out  1  one-PCLK pulse at the end of each captured line.
REQ-016 Port FRAME_DONE  out  1  one-PCLK pulse at the end of each captured frame.
REQ-017 Port LINE_COUNT  out  LINE_W  index of the line currently being captured.
REQ-018 Port PIX_OVF  out  1  sticky flag: a line exceeded 2^ADDR_W pixels.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT_FRAME, LINE, BLANK.
- IDLE -> WAIT_FRAME when CAP_EN=1 and CAM_VSYNC=1.
- WAIT_FRAME -> BLANK on the CAM_VSYNC falling edge (registered).
- BLANK -> LINE on the CAM_HREF rising edge.
- LINE -> BLANK on the CAM_HREF falling edge.
- BLANK or LINE -> IDLE on the CAM_VSYNC rising edge, asserting FRAME_DONE.
REQ-020 In LINE, a byte counter modulo BYTES_PER_PIX SHALL shift CAM_DATA into the pack register; on the last byte the write SHALL assert the next cycle with the completed word (latency 1 PCLK).
REQ-021 LB_WR_ADDR SHALL start at 0 each line and increment after each write.
REQ-022 When LB_WR_ADDR is at 2^ADDR_W-1, further writes SHALL be suppressed for the rest of the line and PIX_OVF SHALL be set; no address wrap.
REQ-023 A partial pixel at the HREF falling edge SHALL be discarded.
REQ-024 LINE_DONE SHALL pulse one cycle after the HREF falling edge; LB_BANK SHALL toggle in that same cycle.
REQ-025 LINE_COUNT SHALL clear at WAIT_FRAME -> BLANK and increment on LINE_DONE, saturating at all-ones.
REQ-026 A VSYNC rise during LINE SHALL abort the line: no LINE_DONE, and FRAME_DONE asserts.
REQ-027 CAP_EN deasserted mid-frame SHALL take effect only after the frame completes.

Reset
REQ-028 RST_N low SHALL force state IDLE and all outputs and counters to 0 (LB_BANK=0, PIX_OVF=0), asynchronously; release is synchronous to PCLK.
REQ-029 PIX_OVF SHALL clear only on reset or on IDLE -> WAIT_FRAME.

Configuration
REQ-030 With CAM_CAPTURE_CROP_EN defined, the block SHALL add input ports CROP_X0 and CROP_X1 (ADDR_W each) and CROP_Y0 and CROP_Y1 (LINE_W each); writes and LINE_DONE occur only for pixels with X0<=x<=X1 on lines with Y0<=y<=Y1, and LB_WR_ADDR is x-X0.
REQ-031 Without CAM_CAPTURE_CROP_EN, the crop ports SHALL be absent and every pixel and line SHALL be captured.

Structure
REQ-032 Package cam_capture_pkg SHALL hold the FSM state enum and the byte-index typedef.
REQ-033 Sub-module cam_pixel_pack SHALL implement the byte-to-pixel packer with the write strobe.

Verification
REQ-034 BYTES_PER_PIX=2, 4-pixel line with bytes 11,22,33,44,55,66,77,88 -> writes at addresses 0..3 with data 1122, 3344, 5566, 7788; then LINE_DONE.
REQ-035 3 lines per frame -> LINE_COUNT 0,1,2; LB_BANK 0,1,0; one FRAME_DONE at the VSYNC rise.
REQ-036 ADDR_W=3 with a 10-pixel line -> 8 writes, addresses 0..7, and PIX_OVF=1.
REQ-037 RST_N low mid-line -> all outputs 0 immediately; capture resumes only at the next VSYNC.
REQ-038 Odd byte count (5 bytes, BYTES_PER_PIX=2) -> 2 writes; the last byte is discarded.
REQ-039 With CAM_CAPTURE_CROP_EN, X0=2, X1=3, Y0=1, Y1=1 -> only line 1 pixels 2..3 are written, at addresses 0..1.
